// File: rtl/psum_wb_pkg.sv
// Shared types and sizing for the partial-sum writeback path: lane entry layout
// and the flush sequencing states.
package psum_wb_pkg;

    localparam int NUM_LANES  = 16;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LANE_W     = $clog2(NUM_LANES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              sel;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/psum_writeback_if.sv
// SRAM write port: a single valid/ready write channel carrying address, data
// and the region select captured with each entry.
interface psum_writeback_if;
    import psum_wb_pkg::*;

    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_sel;
    logic              sram_ready;

    modport master (
        output sram_we,
        output sram_addr,
        output sram_wdata,
        output sram_sel,
        input  sram_ready
    );

    modport slave (
        input  sram_we,
        input  sram_addr,
        input  sram_wdata,
        input  sram_sel,
        output sram_ready
    );

endinterface

// File: rtl/psum_writeback_lane_fifo.sv
// Per-lane synchronous FIFO of writeback entries. Pointers carry one extra
// wrap bit so full and empty are told apart without a counter.
module lane_fifo
    import psum_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t   mem_q [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/psum_writeback.sv
// Collects per-lane PE results into lane FIFOs and serialises them onto one
// SRAM write port with round-robin arbitration and a flush/done sequence.
module psum_writeback
    import psum_wb_pkg::*;
#(
    parameter int FIFO_DEPTH_P = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] DLA_out    [NUM_LANES],
    input  logic              psum_valid [NUM_LANES],
    input  logic [ADDR_W-1:0] psum_addr  [NUM_LANES],
    input  logic              store_is,
    input  logic              flush,
    psum_writeback_if.master  sram,
    output logic              busy,
    output logic              flush_done,
    output logic              overflow
);

    wb_entry_t            entry_in [NUM_LANES];
    wb_entry_t            head     [NUM_LANES];
    logic [NUM_LANES-1:0] valid_vec;
    logic [NUM_LANES-1:0] full_vec;
    logic [NUM_LANES-1:0] empty_vec;
    logic [NUM_LANES-1:0] pop_vec;

    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic [LANE_W-1:0] lock_lane_q, lock_lane_d;
    logic              lock_q, lock_d;
    logic              overflow_q, overflow_d;
    logic              armed_q, armed_d;
    wb_state_t         state_q, state_d;

    logic [LANE_W-1:0] rr_grant;
    logic              rr_found;
    logic [LANE_W-1:0] grant;
    logic              grant_valid;
    logic              xfer;
    logic              any_push;
    logic              all_empty;
    logic              flush_req;
    logic              flush_taken;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign valid_vec[gi]     = psum_valid[gi];
            assign entry_in[gi].addr = psum_addr[gi];
            assign entry_in[gi].data = DLA_out[gi];
            assign entry_in[gi].sel  = store_is;
            assign pop_vec[gi]       = xfer && (grant == LANE_W'(gi));

            lane_fifo #(
                .DEPTH(FIFO_DEPTH_P)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .push     (valid_vec[gi]),
                .push_data(entry_in[gi]),
                .pop      (pop_vec[gi]),
                .full     (full_vec[gi]),
                .empty    (empty_vec[gi]),
                .head     (head[gi])
            );
        end
    endgenerate

    // First non-empty lane at or after the pointer, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!rr_found && !empty_vec[LANE_W'((32'(ptr_q) + k) % NUM_LANES)]) begin
                rr_found = 1'b1;
                rr_grant = LANE_W'((32'(ptr_q) + k) % NUM_LANES);
            end
        end
    end

    // A stalled grant stays put so the SRAM sees stable outputs until it accepts.
    assign grant       = lock_q ? lock_lane_q : rr_grant;
    assign grant_valid = lock_q || rr_found;
    assign xfer        = grant_valid && sram.sram_ready;

    assign sram.sram_we    = grant_valid;
    assign sram.sram_addr  = grant_valid ? head[grant].addr : '0;
    assign sram.sram_wdata = grant_valid ? head[grant].data : '0;
    assign sram.sram_sel   = grant_valid ? head[grant].sel  : 1'b0;

    assign any_push  = |valid_vec;
    assign all_empty = &empty_vec;
    assign flush_req = flush && armed_q;

    always_comb begin
        ptr_d       = ptr_q;
        lock_d      = grant_valid && !sram.sram_ready;
        lock_lane_d = grant;
        overflow_d  = overflow_q | (|(valid_vec & full_vec & ~pop_vec));
        if (xfer) begin
            ptr_d = (grant == LANE_W'(NUM_LANES - 1)) ? '0 : grant + LANE_W'(1);
        end
    end

    // Flush is edge-qualified: once consumed it must drop low before it counts again.
    always_comb begin
        state_d     = state_q;
        flush_taken = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    flush_taken = 1'b1;
                end else if (any_push) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    flush_taken = 1'b1;
                end else if (all_empty && !any_push) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (all_empty && !any_push) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        armed_d = !flush || (armed_q && !flush_taken);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_lane_q <= '0;
            overflow_q  <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_lane_q <= lock_lane_d;
            overflow_q  <= overflow_d;
            armed_q     <= armed_d;
        end
    end

    assign busy       = (state_q != IDLE) || !all_empty;
    assign flush_done = (state_q == DONE);
    assign overflow   = overflow_q;

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Downstream of the DLA core (PE_controller + PE_array) and consumes its per-column outputs: DLA_out[15:0], psum_valid[15:0], psum_addr[15:0] and store_is.
- Buffers up to 16 simultaneous lane results per cycle in per-lane FIFOs.
- Serialises them onto a single SRAM write port using round-robin arbitration with a valid/ready handshake.
- Runs a flush/done sequence triggered by all_done_main.

Parameters:
- NUM_LANES, 16, number of PE output lanes.
- DATA_W, 8, lane data width.
- ADDR_W, 16, psum address width.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- DLA_out  input  [7:0] x16 unpacked  lane result data.
- psum_valid  input  1 x16 unpacked  lane result valid.
- psum_addr  input  [15:0] x16 unpacked  lane destination address.
- store_is  input  1  region select, sampled per push alongside each lane entry.
- flush  input  1  level; start drain-to-done (driven from all_done_main).
- sram_ready  input  1  SRAM port accepts the write this cycle.
- sram_we  output  1  write request valid.
- sram_addr  output  16  write address.
- sram_wdata  output  8  write data.
- sram_sel  output  1  store_is captured with the entry.
- busy  output  1  any FIFO non-empty, or state is not IDLE.
- flush_done  output  1  one-cycle pulse when the flush completes.
- overflow  output  1  sticky; a push was dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFOs empty, arbiter pointer = 0, state = IDLE.
  - sram_we, sram_addr, sram_wdata, sram_sel, busy, flush_done and overflow all = 0.
  - Reset mid-operation discards all buffered entries; no partial write is signalled.
- Push:
  - At each rising edge, every lane i with psum_valid[i]=1 pushes {psum_addr[i], DLA_out[i], store_is} into FIFO i.
  - No backpressure is sent upstream.
- Full lane:
  - A push to a full FIFO i that is not popped in the same cycle is dropped, and overflow is set until reset.
  - Push and pop on the same cycle to a full FIFO both succeed; the occupancy is unchanged.
- Latency: an entry pushed at edge k can appear on sram_we in cycle k+1 at the earliest.
- Arbitration:
  - Round-robin over non-empty FIFOs, starting from the pointer.
  - Grant g is presented combinationally: sram_we=1, with sram_addr, sram_wdata and sram_sel taken from the head of FIFO g.
- Handshake:
  - A transfer occurs when sram_we && sram_ready. FIFO g pops and the pointer becomes (g+1) mod NUM_LANES.
  - While sram_we && !sram_ready, the grant is locked and the outputs are held stable, even if other lanes become non-empty.
  - Throughput: at most 1 write per cycle.
- FSM:
  - IDLE -> RUN on any push.
  - RUN -> FLUSH when flush=1.
  - IDLE -> FLUSH when flush=1.
  - FLUSH -> DONE when all FIFOs are empty and no psum_valid is active in that cycle.
  - DONE: flush_done=1 for exactly one cycle, then IDLE.
  - In FLUSH, pushes are still accepted and delay completion.
  - flush held high after DONE does not retrigger; a new flush needs a 0->1 edge.
- busy = (state != IDLE) || any FIFO non-empty.
- Widths: no arithmetic on data; pointers are log2(FIFO_DEPTH)+1 bits with MSB wrap for full/empty.

Decomposition:
- Shared package psum_wb_pkg holds:
  - constants NUM_LANES, DATA_W, ADDR_W;
  - typedef wb_entry_t {addr, data, sel};
  - enum wb_state_t {IDLE, RUN, FLUSH, DONE}.
- One sub-module, lane_fifo: a parameterised synchronous FIFO of wb_entry_t with push, pop, full, empty and head outputs, instantiated NUM_LANES times.
- The arbiter and FSM live in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-stream with 3 entries buffered.
  - Required: all outputs read 0 and no sram_we follows release.
- Single lane:
  - Stimulus: psum_valid[5]=1, addr=0x0040, data=0x7F, sram_ready=1.
  - Required: sram_we=1 next cycle with addr 0x0040, data 0x7F; busy returns to 0 afterwards.
- All lanes plus round-robin:
  - Stimulus: all 16 lanes valid in one cycle, data=i, addr=0x100+i.
  - Required: 16 consecutive writes in lane order 0..15; no overflow.
- Backpressure:
  - Stimulus: sram_ready=0 for 5 cycles while lanes 2 and 9 hold entries.
  - Required: outputs are stable on lane 2's entry the whole time; when ready returns, lane 2 then lane 9 are written.
- Overflow:
  - Stimulus: lane 0 valid for 6 consecutive cycles with sram_ready=0.
  - Required: first 4 entries kept, overflow=1 from the 5th push; after ready, exactly 4 writes.
- Flush:
  - Stimulus: flush=1 with 3 buffered entries.
  - Required: 3 writes, then flush_done high for exactly 1 cycle, state IDLE, busy=0.
